// File: rtl/alib_point_stream_fifo.sv
// Multi-channel point FIFO with FWFT output, fill-level flags, flush and an
// optional drop-on-full mode that counts discarded points in a saturating counter.
module alib_point_stream_fifo #(
   parameter int DEPTH        = 16,
   parameter int CHANNELS     = 3,
   parameter int CH_WIDTH     = 16,
   parameter int AF_TH        = DEPTH - 2,
   parameter int AE_TH        = 1,
   parameter int DROP_ON_FULL = 0
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              flush,
   input  logic [CHANNELS*CH_WIDTH-1:0]      s_data,
   input  logic                              s_last,
   input  logic                              s_valid,
   output logic                              s_ready,
   output logic [CHANNELS*CH_WIDTH-1:0]      m_data,
   output logic                              m_last,
   output logic                              m_valid,
   input  logic                              m_ready,
   output logic [$clog2(DEPTH+1)-1:0]        level,
   output logic                              almost_full,
   output logic                              almost_empty,
   output logic [15:0]                       drop_count
);

   localparam int DW = CHANNELS * CH_WIDTH;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);
   localparam logic [LW-1:0] FullCnt = LW'(DEPTH);
   localparam logic [LW-1:0] AfCnt   = LW'(AF_TH);
   localparam logic [LW-1:0] AeCnt   = LW'(AE_TH);
   localparam logic [PW-1:0] PtrLast = PW'(DEPTH - 1);

   logic [DW:0]     mem_q [DEPTH];
   logic [PW-1:0]   wp_q, wp_d, rp_q, rp_d;
   logic [LW-1:0]   cnt_q, cnt_d;
   logic [15:0]     drop_q, drop_d;
   logic            full, popEn, pushEn, dropEv;

   // A full FIFO in drop mode still accepts a point when the head leaves in the same cycle.
   always_comb begin
      full    = (cnt_q == FullCnt);
      m_valid = !rst && (cnt_q != '0);
      popEn   = m_valid && m_ready && !flush;
      if (DROP_ON_FULL != 0) begin
         s_ready = !rst;
         pushEn  = s_valid && !rst && !flush && (!full || popEn);
         dropEv  = s_valid && !rst && !flush && full && !popEn;
      end else begin
         s_ready = !rst && !full;
         pushEn  = s_valid && s_ready && !flush;
         dropEv  = 1'b0;
      end
   end

   always_comb begin
      wp_d   = wp_q;
      rp_d   = rp_q;
      cnt_d  = cnt_q;
      drop_d = drop_q;
      if (flush) begin
         wp_d  = '0;
         rp_d  = '0;
         cnt_d = '0;
      end else begin
         if (pushEn) wp_d = (wp_q == PtrLast) ? '0 : wp_q + 1'b1;
         if (popEn)  rp_d = (rp_q == PtrLast) ? '0 : rp_q + 1'b1;
         case ({pushEn, popEn})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
         if (dropEv && (drop_q != 16'hFFFF)) drop_d = drop_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wp_q   <= '0;
         rp_q   <= '0;
         cnt_q  <= '0;
         drop_q <= '0;
      end else begin
         wp_q   <= wp_d;
         rp_q   <= rp_d;
         cnt_q  <= cnt_d;
         drop_q <= drop_d;
      end
   end

   // Storage is deliberately left out of reset; only occupied entries are ever presented.
   always_ff @(posedge clk) begin
      if (pushEn) mem_q[wp_q] <= {s_last, s_data};
   end

   assign {m_last, m_data} = mem_q[rp_q];
   assign level            = cnt_q;
   assign almost_full      = (cnt_q >= AfCnt);
   assign almost_empty     = (cnt_q <= AeCnt);
   assign drop_count       = drop_q;

endmodule
